// File: rtl/regfile_sequencer_if.sv
// Bundle of the command, ALU and register-file signals owned by the sequencer.
interface regfile_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    // command handshake from decode
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic              cmd_imm_en;
    logic [DATA_W-1:0] cmd_imm;
    logic [ADDR_W-1:0] cmd_dst;
    logic              cmd_wb_en;

    // ALU side
    logic              alu_valid;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_done;
    logic [DATA_W-1:0] alu_result;

    // register file read port
    logic [ADDR_W-1:0] rf_s_out;
    logic              rf_out_en;
    logic [DATA_W-1:0] rf_d_out;

    // register file write port
    logic [ADDR_W-1:0] rf_s_in;
    logic [DATA_W-1:0] rf_d_in;
    logic              rf_write_en;

    // completion status
    logic              done;
    logic              err;

    // environment side: decode stage, ALU and register file
    modport master (
        output cmd_valid, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm, cmd_dst, cmd_wb_en,
        output alu_done, alu_result, rf_d_out,
        input  cmd_ready, alu_valid, alu_a, alu_b,
        input  rf_s_out, rf_out_en, rf_s_in, rf_d_in, rf_write_en, done, err
    );

    // sequencer side
    modport slave (
        input  cmd_valid, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm, cmd_dst, cmd_wb_en,
        input  alu_done, alu_result, rf_d_out,
        output cmd_ready, alu_valid, alu_a, alu_b,
        output rf_s_out, rf_out_en, rf_s_in, rf_d_in, rf_write_en, done, err
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Serialises register-file reads, ALU execution and writeback for one command at a time.
module regfile_sequencer #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned ALU_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_sequencer_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t            state_q, state_d;

    // set one edge after reset release so no command is taken during the release cycle
    logic              live_q;

    logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q;
    logic              imm_en_q, wb_en_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q, err_q;

    logic              accept, load_a, load_b, load_res, cnt_clr, cnt_inc;
    logic              done_d, err_d;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, datapath strobes and state-decoded outputs
    always_comb begin
        state_d         = state_q;
        accept          = 1'b0;
        load_a          = 1'b0;
        load_b          = 1'b0;
        load_res        = 1'b0;
        cnt_clr         = 1'b0;
        cnt_inc         = 1'b0;
        done_d          = 1'b0;
        err_d           = 1'b0;
        bus.cmd_ready   = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.rf_out_en   = 1'b0;
        bus.rf_s_out    = '0;
        bus.rf_s_in     = '0;
        bus.rf_d_in     = '0;
        bus.rf_write_en = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bus.cmd_ready = live_q;
                if (live_q && bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                bus.rf_out_en = 1'b1;
                bus.rf_s_out  = src_a_q;
                load_a        = 1'b1;
                if (imm_en_q) begin
                    cnt_clr = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_RD_B;
                end
            end
            S_RD_B: begin
                bus.rf_out_en = 1'b1;
                bus.rf_s_out  = src_b_q;
                load_b        = 1'b1;
                cnt_clr       = 1'b1;
                state_d       = S_EXEC;
            end
            S_EXEC: begin
                bus.alu_valid = 1'b1;
                bus.alu_a     = op_a_q;
                bus.alu_b     = op_b_q;
                cnt_inc       = 1'b1;
                // a result in the last permitted cycle still counts as success
                if (bus.alu_done) begin
                    load_res = 1'b1;
                    if (wb_en_q) begin
                        state_d = S_WB;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CNT_W'(ALU_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                bus.rf_write_en = 1'b1;
                bus.rf_s_in     = dst_q;
                bus.rf_d_in     = result_q;
                done_d          = 1'b1;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // command, operand, result and timeout registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= 1'b0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            imm_en_q <= 1'b0;
            wb_en_q  <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                src_a_q  <= bus.cmd_src_a;
                src_b_q  <= bus.cmd_src_b;
                dst_q    <= bus.cmd_dst;
                imm_en_q <= bus.cmd_imm_en;
                wb_en_q  <= bus.cmd_wb_en;
                if (bus.cmd_imm_en) begin
                    op_b_q <= bus.cmd_imm;
                end
            end
            if (load_a) begin
                op_a_q <= bus.rf_d_out;
            end
            if (load_b) begin
                op_b_q <= bus.rf_d_out;
            end
            if (load_res) begin
                result_q <= bus.alu_result;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // completion pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench: bench register file and adder ALU around the sequencer, with a
// behavioural register model predicting operands, writebacks and completion cycles.
module tb_regfile_sequencer;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ADDR_W      = 3;
    localparam int unsigned ALU_TIMEOUT = 15;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    regfile_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // bench register file: combinational read, write on rising edge
    logic [7:0] rf_mem [8];
    logic [7:0] mrf    [8];
    assign bus.rf_d_out = rf_mem[bus.rf_s_out];
    always @(posedge clk) begin
        if (bus.rf_write_en) rf_mem[bus.rf_s_in] <= bus.rf_d_in;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // hard time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [43:0] all_outs();
        return {bus.cmd_ready, bus.alu_valid, bus.alu_a, bus.alu_b, bus.rf_s_out, bus.rf_out_en,
                bus.rf_s_in, bus.rf_d_in, bus.rf_write_en, bus.done, bus.err, 3'b000};
    endfunction

    // Drives one command starting at a negedge and watches it until done/err/abort.
    // lat = EXEC cycle on which the bench ALU answers (0 = never); abort 1 = reset in EXEC, 2 = in WB.
    task automatic run_cmd(input logic [2:0] sa, input logic [2:0] sb, input logic ie,
                           input logic [7:0] im, input logic [2:0] ds, input logic we,
                           input int lat, input logic poke, input int abort,
                           output int done_c, output int err_c, output int exec_c, output int wb_c,
                           output int rd_cnt, output int wr_cnt, output logic [7:0] ga,
                           output logic [7:0] gb, output logic stable, output logic [2:0] wa,
                           output logic [7:0] wd, output logic acc_ok, output logic poke_acc,
                           output logic [43:0] outs_after);
        int n;
        done_c = -1; err_c = -1; exec_c = -1; wb_c = -1; rd_cnt = 0; wr_cnt = 0;
        ga = '0; gb = '0; stable = 1'b1; wa = '0; wd = '0; poke_acc = 1'b0; outs_after = '0;
        n = 0;
        bus.cmd_src_a = sa; bus.cmd_src_b = sb; bus.cmd_imm_en = ie; bus.cmd_imm = im;
        bus.cmd_dst = ds; bus.cmd_wb_en = we; bus.cmd_valid = 1'b1;
        acc_ok = bus.cmd_ready;
        @(posedge clk);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (bus.rf_out_en) rd_cnt++;
            if (bus.rf_write_en) begin
                wr_cnt++; wa = bus.rf_s_in; wd = bus.rf_d_in; wb_c = cyc;
            end
            if (bus.done) begin done_c = cyc; break; end
            if (bus.err)  begin err_c = cyc;  break; end
            if ((abort == 1 && bus.alu_valid) || (abort == 2 && bus.rf_write_en)) begin
                rst_n = 1'b0;
                #1;
                outs_after = all_outs();
                break;
            end
            if (bus.alu_valid) begin
                n++;
                if (n == 1) begin
                    exec_c = cyc; ga = bus.alu_a; gb = bus.alu_b;
                end else if (bus.alu_a !== ga || bus.alu_b !== gb) begin
                    stable = 1'b0;
                end
                bus.alu_done   = (n == lat);
                bus.alu_result = 8'(bus.alu_a + bus.alu_b);
                if (poke && n == 1) begin
                    bus.cmd_valid = 1'b1;
                    poke_acc = bus.cmd_ready;
                end
            end else begin
                bus.alu_done = 1'b0;
            end
        end
        bus.alu_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_src_a = 3'd1; bus.cmd_src_b = 3'd2; bus.cmd_imm_en = 1'b0;
        bus.cmd_imm = 8'h55; bus.cmd_dst = 3'd3; bus.cmd_wb_en = 1'b1;
        bus.alu_done = 1'b1; bus.alu_result = 8'hAA;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs() !== 44'h0) begin
            fails++; $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        bus.alu_done = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            fails++; $display("FAIL reset_release_ready: got %b required 0", bus.cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rf_out_en !== 1'b0) begin
            fails++; $display("FAIL reset_first_cycle: ready %b rd_en %b required 1 0",
                              bus.cmd_ready, bus.rf_out_en);
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rf_out_en !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL reset_no_accept: rd_en %b ready %b required 0 1",
                              bus.rf_out_en, bus.cmd_ready);
        end
    endtask

    task automatic test_preload_add();
        int dc, ec, xc, wc, rc, wn; logic [7:0] ga, gb, wd; logic st, ak, pk; logic [2:0] wa;
        logic [43:0] oa;
        run_cmd(3'd0, 3'd0, 1'b1, 8'h12, 3'd1, 1'b1, 1, 1'b0, 0, dc, ec, xc, wc, rc, wn, ga, gb, st, wa, wd, ak, pk, oa);
        mrf[1] = 8'h12;
        checks++;
        if (ak !== 1'b1 || dc != 4 || wa !== 3'd1 || wd !== 8'h12) begin
            fails++; $display("FAIL preload_r1: acc %b done_c %0d wa %0d wd %h required 1 4 1 12", ak, dc, wa, wd);
        end
        run_cmd(3'd0, 3'd0, 1'b1, 8'h34, 3'd2, 1'b1, 1, 1'b0, 0, dc, ec, xc, wc, rc, wn, ga, gb, st, wa, wd, ak, pk, oa);
        mrf[2] = 8'h34;
        checks++;
        if (ak !== 1'b1 || dc != 4 || wa !== 3'd2 || wd !== 8'h34) begin
            fails++; $display("FAIL preload_r2: acc %b done_c %0d wa %0d wd %h required 1 4 2 34", ak, dc, wa, wd);
        end
        run_cmd(3'd1, 3'd2, 1'b0, 8'h00, 3'd3, 1'b1, 1, 1'b0, 0, dc, ec, xc, wc, rc, wn, ga, gb, st, wa, wd, ak, pk, oa);
        mrf[3] = 8'(mrf[1] + mrf[2]);
        checks++;
        if (xc != 3 || ga !== 8'h12 || gb !== 8'h34) begin
            fails++; $display("FAIL add_operands: exec_c %0d a %h b %h required 3 12 34", xc, ga, gb);
        end
        checks++;
        if (wc != 4 || wn != 1 || wa !== 3'd3 || wd !== mrf[3] || rc != 2) begin
            fails++; $display("FAIL add_writeback: wb_c %0d n %0d wa %0d wd %h reads %0d required 4 1 3 %h 2",
                              wc, wn, wa, wd, rc, mrf[3]);
        end
        checks++;
        if (dc != 5 || bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL add_done: done_c %0d ready %b required 5 1", dc, bus.cmd_ready);
        end
    endtask

    task automatic test_immediate();
        int dc, ec, xc, wc, rc, wn; logic [7:0] ga, gb, wd; logic st, ak, pk; logic [2:0] wa;
        logic [43:0] oa;
        run_cmd(3'd3, 3'd5, 1'b1, 8'hFF, 3'd4, 1'b1, 1, 1'b0, 0, dc, ec, xc, wc, rc, wn, ga, gb, st, wa, wd, ak, pk, oa);
        mrf[4] = 8'(mrf[3] + 8'hFF);
        checks++;
        if (rc != 1 || xc != 2 || dc != 4 || wa !== 3'd4 || wd !== 8'h45) begin
            fails++; $display("FAIL imm_path: reads %0d exec_c %0d done_c %0d wa %0d wd %h required 1 2 4 4 45",
                              rc, xc, dc, wa, wd);
        end
    endtask

    task automatic test_slow_alu();
        int dc, ec, xc, wc, rc, wn; logic [7:0] ga, gb, wd; logic st, ak, pk; logic [2:0] wa;
        logic [43:0] oa;
        run_cmd(3'd1, 3'd2, 1'b0, 8'h00, 3'd5, 1'b1, 3, 1'b1, 0, dc, ec, xc, wc, rc, wn, ga, gb, st, wa, wd, ak, pk, oa);
        mrf[5] = 8'(mrf[1] + mrf[2]);
        checks++;
        if (st !== 1'b1 || ga !== mrf[1] || gb !== mrf[2]) begin
            fails++; $display("FAIL slow_stable: stable %b a %h b %h required 1 %h %h", st, ga, gb, mrf[1], mrf[2]);
        end
        checks++;
        if (dc != 7 || wd !== mrf[5] || pk !== 1'b0) begin
            fails++; $display("FAIL slow_done: done_c %0d wd %h poke_ready %b required 7 %h 0", dc, wd, pk, mrf[5]);
        end
        @(negedge clk);
        checks++;
        if (bus.rf_out_en !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL slow_no_accept: rd_en %b done %b ready %b required 0 0 1",
                              bus.rf_out_en, bus.done, bus.cmd_ready);
        end
    endtask

    task automatic test_timeout();
        int dc, ec, xc, wc, rc, wn; logic [7:0] ga, gb, wd; logic st, ak, pk; logic [2:0] wa;
        logic [43:0] oa; logic same;
        run_cmd(3'd1, 3'd2, 1'b0, 8'h00, 3'd6, 1'b1, 0, 1'b0, 0, dc, ec, xc, wc, rc, wn, ga, gb, st, wa, wd, ak, pk, oa);
        checks++;
        if (ec != 3 + int'(ALU_TIMEOUT) || dc != -1 || wn != 0 || bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL timeout_err: err_c %0d done_c %0d writes %0d ready %b required %0d -1 0 1",
                              ec, dc, wn, bus.cmd_ready, 3 + int'(ALU_TIMEOUT));
        end
        @(negedge clk);
        same = 1'b1;
        for (int i = 0; i < 8; i++) if (rf_mem[i] !== mrf[i]) same = 1'b0;
        checks++;
        if (bus.err !== 1'b0 || same !== 1'b1) begin
            fails++; $display("FAIL timeout_after: err %b regs_same %b required 0 1", bus.err, same);
        end
        run_cmd(3'd1, 3'd2, 1'b0, 8'h00, 3'd6, 1'b1, int'(ALU_TIMEOUT), 1'b0, 0, dc, ec, xc, wc, rc, wn, ga, gb, st, wa, wd, ak, pk, oa);
        mrf[6] = 8'(mrf[1] + mrf[2]);
        checks++;
        if (dc != 4 + int'(ALU_TIMEOUT) || ec != -1 || wd !== mrf[6] || wn != 1) begin
            fails++; $display("FAIL timeout_last_cycle: done_c %0d err_c %0d wd %h writes %0d required %0d -1 %h 1",
                              dc, ec, wd, wn, 4 + int'(ALU_TIMEOUT), mrf[6]);
        end
    endtask

    task automatic test_reset_mid();
        int dc, ec, xc, wc, rc, wn; logic [7:0] ga, gb, wd; logic st, ak, pk; logic [2:0] wa;
        logic [43:0] oa;
        run_cmd(3'd1, 3'd2, 1'b0, 8'h00, 3'd7, 1'b1, 0, 1'b0, 1, dc, ec, xc, wc, rc, wn, ga, gb, st, wa, wd, ak, pk, oa);
        checks++;
        if (oa !== 44'h0 || dc != -1 || ec != -1) begin
            fails++; $display("FAIL reset_exec_outs: got %h done_c %0d err_c %0d required 0 -1 -1", oa, dc, ec);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rf_mem[7] !== mrf[7] || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            fails++; $display("FAIL reset_exec_nowrite: r7 %h done %b err %b required %h 0 0",
                              rf_mem[7], bus.done, bus.err, mrf[7]);
        end
        run_cmd(3'd3, 3'd0, 1'b1, 8'h01, 3'd0, 1'b1, 1, 1'b0, 2, dc, ec, xc, wc, rc, wn, ga, gb, st, wa, wd, ak, pk, oa);
        checks++;
        if (oa !== 44'h0 || wn != 1) begin
            fails++; $display("FAIL reset_wb_outs: got %h writes_seen %0d required 0 1", oa, wn);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rf_mem[0] !== mrf[0] || bus.done !== 1'b0) begin
            fails++; $display("FAIL reset_wb_nowrite: r0 %h done %b required %h 0", rf_mem[0], bus.done, mrf[0]);
        end
        run_cmd(3'd1, 3'd2, 1'b0, 8'h00, 3'd7, 1'b1, 1, 1'b0, 0, dc, ec, xc, wc, rc, wn, ga, gb, st, wa, wd, ak, pk, oa);
        mrf[7] = 8'(mrf[1] + mrf[2]);
        checks++;
        if (ak !== 1'b1 || dc != 5 || wa !== 3'd7 || wd !== mrf[7]) begin
            fails++; $display("FAIL reset_recover: acc %b done_c %0d wa %0d wd %h required 1 5 7 %h",
                              ak, dc, wa, wd, mrf[7]);
        end
    endtask

    task automatic test_back_to_back_random();
        int dc, ec, xc, wc, rc, wn; logic [7:0] ga, gb, wd; logic st, ak, pk; logic [2:0] wa;
        logic [43:0] oa;
        logic [2:0] sa, sb, ds; logic ie, we; logic [7:0] im, ea, eb; int lat, edc;
        for (int k = 0; k < 30; k++) begin
            sa = 3'($urandom_range(0, 7)); sb = 3'($urandom_range(0, 7)); ds = 3'($urandom_range(0, 7));
            ie = 1'($urandom_range(0, 1)); we = ($urandom_range(0, 3) != 0);
            im = 8'($urandom_range(0, 255)); lat = int'($urandom_range(1, 4));
            ea = mrf[sa];
            eb = ie ? im : mrf[sb];
            edc = (ie ? 2 : 3) + lat + (we ? 1 : 0);
            run_cmd(sa, sb, ie, im, ds, we, lat, 1'b0, 0, dc, ec, xc, wc, rc, wn, ga, gb, st, wa, wd, ak, pk, oa);
            checks++;
            if (ak !== 1'b1 || dc != edc || ec != -1 || ga !== ea || gb !== eb || st !== 1'b1) begin
                fails++; $display("FAIL rand_cmd%0d: acc %b done_c %0d err_c %0d a %h b %h required 1 %0d -1 %h %h",
                                  k, ak, dc, ec, ga, gb, edc, ea, eb);
            end
            checks++;
            if (wn != (we ? 1 : 0) || (we && (wa !== ds || wd !== 8'(ea + eb)))) begin
                fails++; $display("FAIL rand_wb%0d: writes %0d wa %0d wd %h required %0d %0d %h",
                                  k, wn, wa, wd, we ? 1 : 0, ds, 8'(ea + eb));
            end
            if (we) mrf[ds] = 8'(ea + eb);
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rf_mem[i] !== mrf[i]) begin
                fails++; $display("FAIL rand_final_r%0d: got %h required %h", i, rf_mem[i], mrf[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        for (int i = 0; i < 8; i++) begin
            rf_mem[i] = 8'h00;
            mrf[i]    = 8'h00;
        end
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_src_a = '0; bus.cmd_src_b = '0; bus.cmd_imm_en = 1'b0;
        bus.cmd_imm = '0; bus.cmd_dst = '0; bus.cmd_wb_en = 1'b0;
        bus.alu_done = 1'b0; bus.alu_result = '0;
        test_reset();
        test_preload_add();
        test_immediate();
        test_slow_alu();
        test_timeout();
        test_reset_mid();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
